// File: rtl/vec_mem_sequencer.sv
// vec_mem_sequencer: element-wise vector engine over a dual-port DMem.
// Walks vectors A and B, computes op(a, b) per element and writes the
// result to the destination vector, three cycles per element
// (RD -> WT -> WR). Port A is read-only; port B reads B then writes the result.
// Optional build macro VEC_STRIDE_EN adds per-vector address strides
// (stride_a, stride_b, stride_d); without it every stride is 1.
module vec_mem_sequencer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [15:0]       src_a,
  input  logic [15:0]       src_b,
  input  logic [15:0]       dst,
  input  logic [LEN_W-1:0]  len,
`ifdef VEC_STRIDE_EN
  input  logic [15:0]       stride_a,
  input  logic [15:0]       stride_b,
  input  logic [15:0]       stride_d,
`endif
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  elem_idx,
  output logic [ADDR_W-1:0] mem_addra,
  input  logic [DATA_W-1:0] mem_douta,
  output logic              mem_web,
  output logic [ADDR_W-1:0] mem_addrb,
  output logic [DATA_W-1:0] mem_dinb,
  input  logic [DATA_W-1:0] mem_doutb
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] WT   = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] FIN  = 3'd4;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_COPY = 4'd5;

  logic [2:0]        state;
  logic [3:0]        opR;
  logic [LEN_W-1:0]  lenR;
  logic [LEN_W-1:0]  idx;
  logic [ADDR_W-1:0] ptrA;
  logic [ADDR_W-1:0] ptrB;
  logic [ADDR_W-1:0] ptrD;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] result;
  logic              errR;
  logic              illegalOp;
  logic              lastElem;

  // Per-element address increments: running accumulators instead of i*stride.
  logic [ADDR_W-1:0] stepA;
  logic [ADDR_W-1:0] stepB;
  logic [ADDR_W-1:0] stepD;
  logic              unusedBits;

`ifdef VEC_STRIDE_EN
  // Strides are captured at start so the caller may change them mid-run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stepA <= '0;
      stepB <= '0;
      stepD <= '0;
    end else if (state == IDLE && start) begin
      stepA <= stride_a[ADDR_W-1:0];
      stepB <= stride_b[ADDR_W-1:0];
      stepD <= stride_d[ADDR_W-1:0];
    end
  end

  assign unusedBits = ^{src_a[15:ADDR_W], src_b[15:ADDR_W], dst[15:ADDR_W],
                        stride_a[15:ADDR_W], stride_b[15:ADDR_W], stride_d[15:ADDR_W]};
`else
  assign stepA = ADDR_W'(1);
  assign stepB = ADDR_W'(1);
  assign stepD = ADDR_W'(1);

  assign unusedBits = ^{src_a[15:ADDR_W], src_b[15:ADDR_W], dst[15:ADDR_W]};
`endif

  assign illegalOp = (op > OP_COPY);
  assign lastElem  = (idx == lenR - LEN_W'(1));

  // Sequencer state, latched command, element pointers and operand capture.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; the async reset clears them immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      opR   <= '0;
      lenR  <= '0;
      idx   <= '0;
      ptrA  <= '0;
      ptrB  <= '0;
      ptrD  <= '0;
      opa   <= '0;
      opb   <= '0;
      errR  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opR  <= op;
            lenR <= len;
            idx  <= '0;
            ptrA <= src_a[ADDR_W-1:0];
            ptrB <= src_b[ADDR_W-1:0];
            ptrD <= dst[ADDR_W-1:0];
            errR <= illegalOp;
            if (illegalOp || len == '0) state <= FIN;
            else                        state <= RD;
          end
        end
        RD: state <= WT;
        WT: begin
          // Registered BRAM outputs for the RD addresses are valid now.
          opa   <= mem_douta;
          opb   <= mem_doutb;
          state <= WR;
        end
        WR: begin
          if (lastElem) begin
            state <= FIN;
          end else begin
            idx   <= idx + LEN_W'(1);
            ptrA  <= ptrA + stepA;
            ptrB  <= ptrB + stepB;
            ptrD  <= ptrD + stepD;
            state <= RD;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Element function, modulo 2^DATA_W; SUB simply wraps.
  // NOTE: always_comb gets a default assignment first so no path can infer a latch.
  always_comb begin
    result = '0;
    case (opR)
      OP_ADD:  result = opa + opb;
      OP_SUB:  result = opa - opb;
      OP_AND:  result = opa & opb;
      OP_OR:   result = opa | opb;
      OP_XOR:  result = opa ^ opb;
      OP_COPY: result = opa;
      default: result = '0;
    endcase
  end

  // Port B carries the B-vector read address except in WR, where it writes.
  assign mem_addra = ptrA;
  assign mem_addrb = (state == WR) ? ptrD : ptrB;
  assign mem_web   = (state == WR);
  assign mem_dinb  = result;
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign err       = errR;
  assign elem_idx  = idx;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// tb_vec_mem_sequencer: directed self-checking bench for vec_mem_sequencer.
// Models the dual-port DMem with 1-cycle read latency; expected values are
// hand-computed constants. Stride cases build when VEC_STRIDE_EN is defined.
module tb_vec_mem_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [15:0] src_a;
  logic [15:0] src_b;
  logic [15:0] dst;
  logic [15:0] len;
`ifdef VEC_STRIDE_EN
  logic [15:0] stride_a;
  logic [15:0] stride_b;
  logic [15:0] stride_d;
`endif
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] elem_idx;
  logic [9:0]  mem_addra;
  logic [15:0] mem_douta;
  logic        mem_web;
  logic [9:0]  mem_addrb;
  logic [15:0] mem_dinb;
  logic [15:0] mem_doutb;

  logic [15:0] mem [0:1023];
  logic        tbWe;
  logic [9:0]  tbAddr;
  logic [15:0] tbData;

  int total;
  int bad;
  int doneCyc;
  int busyCnt;
  int webCnt;
  logic [9:0] rdAddr [0:7];

  vec_mem_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .dst       (dst),
    .len       (len),
`ifdef VEC_STRIDE_EN
    .stride_a  (stride_a),
    .stride_b  (stride_b),
    .stride_d  (stride_d),
`endif
    .busy      (busy),
    .done      (done),
    .err       (err),
    .elem_idx  (elem_idx),
    .mem_addra (mem_addra),
    .mem_douta (mem_douta),
    .mem_web   (mem_web),
    .mem_addrb (mem_addrb),
    .mem_dinb  (mem_dinb),
    .mem_doutb (mem_doutb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Dual-port BRAM model: registered reads, read-first port B, bench preload port.
  always @(posedge clk) begin
    mem_douta <= mem[mem_addra];
    mem_doutb <= mem[mem_addrb];
    if (tbWe)         mem[tbAddr]    <= tbData;
    else if (mem_web) mem[mem_addrb] <= mem_dinb;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [15:0] d);
    @(negedge clk);
    tbWe = 1'b1; tbAddr = a; tbData = d;
    @(negedge clk);
    tbWe = 1'b0;
  endtask

  // Issue one command and watch it; rstAt > 0 asserts reset in that cycle.
  task automatic runOp(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] d, input logic [15:0] n,
                       input bit holdStart, input int pulseAt, input int rstAt);
    int cyc;
    @(negedge clk);
    op = o; src_a = a; src_b = b; dst = d; len = n; start = 1'b1;
    @(posedge clk);
    #1;
    if (!holdStart) start = 1'b0;
    op = 4'd15; src_a = 16'hFFFF; src_b = 16'hFFFF; dst = 16'hFFFF; len = 16'd9;
    cyc = 0; doneCyc = -1; busyCnt = 0; webCnt = 0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (!holdStart) start = (cyc == pulseAt);
      if (cyc == rstAt) begin
        reset = 1'b0;
        #1;
        check("rst_web_async", {31'd0, mem_web}, 32'd0);
        check("rst_busy_async", {31'd0, busy}, 32'd0);
        break;
      end
      if (busy) busyCnt++;
      if (mem_web) webCnt++;
      if ((cyc - 1) % 3 == 0 && (cyc - 1) / 3 < 8) rdAddr[(cyc - 1) / 3] = mem_addra;
      if (done) begin
        doneCyc = cyc;
        start = 1'b0;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    tbWe = 1'b0; tbAddr = '0; tbData = '0;
    reset = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0; dst = '0; len = '0;
`ifdef VEC_STRIDE_EN
    stride_a = 16'd1; stride_b = 16'd1; stride_d = 16'd1;
`endif
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_web", {31'd0, mem_web}, 32'd0);
    check("rst_addra", {22'd0, mem_addra}, 32'd0);
    check("rst_addrb", {22'd0, mem_addrb}, 32'd0);
    check("rst_dinb", {16'd0, mem_dinb}, 32'd0);
    check("rst_idx", {16'd0, elem_idx}, 32'd0);
    reset = 1'b1;

    // ADD, len 4.
    for (int i = 0; i < 4; i++) begin
      poke(10'h010 + 10'(i), 16'(i + 1));
      poke(10'h020 + 10'(i), 16'(10 * (i + 1)));
    end
    runOp(4'd0, 16'h010, 16'h020, 16'h030, 16'd4, 1'b0, -1, 0);
    check("add_done_cyc", doneCyc, 32'd13);
    check("add_busy_cnt", busyCnt, 32'd13);
    check("add_web_cnt", webCnt, 32'd4);
    check("add_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    check("add_idle_busy", {31'd0, busy}, 32'd0);
    check("add_d0", {16'd0, mem[10'h030]}, 32'd11);
    check("add_d1", {16'd0, mem[10'h031]}, 32'd22);
    check("add_d2", {16'd0, mem[10'h032]}, 32'd33);
    check("add_d3", {16'd0, mem[10'h033]}, 32'd44);

    // SUB wraps: 0 - 1.
    poke(10'h040, 16'd0);
    poke(10'h041, 16'd1);
    runOp(4'd1, 16'h040, 16'h041, 16'h042, 16'd1, 1'b0, -1, 0);
    check("sub_done_cyc", doneCyc, 32'd4);
    check("sub_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    check("sub_result", {16'd0, mem[10'h042]}, 32'h0000FFFF);

    // len = 0.
    runOp(4'd0, 16'h010, 16'h020, 16'h030, 16'd0, 1'b0, -1, 0);
    check("len0_done_cyc", doneCyc, 32'd1);
    check("len0_web_cnt", webCnt, 32'd0);
    check("len0_err", {31'd0, err}, 32'd0);

    // Illegal op 7: err set and held until the next accepted start.
    runOp(4'd7, 16'h010, 16'h020, 16'h030, 16'd3, 1'b0, -1, 0);
    check("ill_done_cyc", doneCyc, 32'd1);
    check("ill_web_cnt", webCnt, 32'd0);
    check("ill_err", {31'd0, err}, 32'd1);
    repeat (3) @(negedge clk);
    check("ill_err_held", {31'd0, err}, 32'd1);
    runOp(4'd0, 16'h010, 16'h020, 16'h030, 16'd0, 1'b0, -1, 0);
    check("ill_err_cleared", {31'd0, err}, 32'd0);

    // COPY across the top of the address space.
    poke(10'h3FE, 16'h00A1);
    poke(10'h3FF, 16'h00A2);
    poke(10'h000, 16'h00A3);
    poke(10'h001, 16'h00A4);
    runOp(4'd5, 16'h03FE, 16'h0200, 16'h0100, 16'd4, 1'b0, -1, 0);
    check("copy_done_cyc", doneCyc, 32'd13);
    check("copy_rd0", {22'd0, rdAddr[0]}, 32'h3FE);
    check("copy_rd1", {22'd0, rdAddr[1]}, 32'h3FF);
    check("copy_rd2", {22'd0, rdAddr[2]}, 32'h000);
    check("copy_rd3", {22'd0, rdAddr[3]}, 32'h001);
    @(negedge clk);
    check("copy_d0", {16'd0, mem[10'h100]}, 32'h00A1);
    check("copy_d1", {16'd0, mem[10'h101]}, 32'h00A2);
    check("copy_d2", {16'd0, mem[10'h102]}, 32'h00A3);
    check("copy_d3", {16'd0, mem[10'h103]}, 32'h00A4);

    // XOR with start held high until done: exactly one operation.
    poke(10'h050, 16'h00FF);
    poke(10'h051, 16'h1234);
    poke(10'h060, 16'h0F0F);
    poke(10'h061, 16'hFFFF);
    runOp(4'd4, 16'h050, 16'h060, 16'h070, 16'd2, 1'b1, -1, 0);
    check("hold_done_cyc", doneCyc, 32'd7);
    check("hold_web_cnt", webCnt, 32'd2);
    @(negedge clk);
    check("hold_idle_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("hold_no_restart", {31'd0, busy}, 32'd0);
    check("hold_d0", {16'd0, mem[10'h070]}, 32'h0FF0);
    check("hold_d1", {16'd0, mem[10'h071]}, 32'hEDCB);

    // In-place XOR (dst = src_a) with an extra start pulse while busy.
    poke(10'h080, 16'hAAAA);
    poke(10'h081, 16'h5555);
    poke(10'h090, 16'hFFFF);
    poke(10'h091, 16'h0F0F);
    runOp(4'd4, 16'h080, 16'h090, 16'h080, 16'd2, 1'b0, 2, 0);
    check("inpl_done_cyc", doneCyc, 32'd7);
    check("inpl_web_cnt", webCnt, 32'd2);
    @(negedge clk);
    check("inpl_idle_busy", {31'd0, busy}, 32'd0);
    check("inpl_d0", {16'd0, mem[10'h080]}, 32'h5555);
    check("inpl_d1", {16'd0, mem[10'h081]}, 32'h5A5A);

    // Reset during WR of element 2 of 5 (cycle 9).
    for (int i = 0; i < 5; i++) begin
      poke(10'h0A0 + 10'(i), 16'(i + 1));
      poke(10'h0B0 + 10'(i), 16'd10);
      poke(10'h0C0 + 10'(i), 16'hDEAD);
    end
    runOp(4'd0, 16'h0A0, 16'h0B0, 16'h0C0, 16'd5, 1'b0, -1, 9);
    repeat (2) @(negedge clk);
    check("rstmid_idx", {16'd0, elem_idx}, 32'd0);
    check("rstmid_done", {31'd0, done}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_c0", {16'd0, mem[10'h0C0]}, 32'd11);
    check("rstmid_c1", {16'd0, mem[10'h0C1]}, 32'd12);
    check("rstmid_c2", {16'd0, mem[10'h0C2]}, 32'hDEAD);
    check("rstmid_c3", {16'd0, mem[10'h0C3]}, 32'hDEAD);
    check("rstmid_c4", {16'd0, mem[10'h0C4]}, 32'hDEAD);
    runOp(4'd0, 16'h0A0, 16'h0B0, 16'h0C0, 16'd5, 1'b0, -1, 0);
    check("rerun_done_cyc", doneCyc, 32'd16);
    check("rerun_web_cnt", webCnt, 32'd5);
    @(negedge clk);
    check("rerun_c2", {16'd0, mem[10'h0C2]}, 32'd13);
    check("rerun_c4", {16'd0, mem[10'h0C4]}, 32'd15);

`ifdef VEC_STRIDE_EN
    // stride_a=2, stride_d=0: A at 0x200,0x202,0x204; dst keeps last result.
    poke(10'h200, 16'd5);
    poke(10'h202, 16'd7);
    poke(10'h204, 16'd9);
    poke(10'h210, 16'd100);
    poke(10'h211, 16'd200);
    poke(10'h212, 16'd300);
    poke(10'h221, 16'hBEEF);
    @(negedge clk);
    stride_a = 16'd2; stride_b = 16'd1; stride_d = 16'd0;
    runOp(4'd0, 16'h200, 16'h210, 16'h220, 16'd3, 1'b0, -1, 0);
    stride_a = 16'd1; stride_b = 16'd1; stride_d = 16'd1;
    check("stride_done_cyc", doneCyc, 32'd10);
    check("stride_web_cnt", webCnt, 32'd3);
    check("stride_rd2", {22'd0, rdAddr[2]}, 32'h204);
    @(negedge clk);
    check("stride_dst", {16'd0, mem[10'h220]}, 32'd309);
    check("stride_next", {16'd0, mem[10'h221]}, 32'hBEEF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vec_mem_sequencer.md
Name: vec_mem_sequencer

Overview:
- Element-wise vector engine for the memory-to-memory datapath: given two source bases, a destination base, a length and an op, it walks both vectors in the dual-port DMem, computes each result internally and writes it back.
- Sits beside the Control unit, which issues one start per vector instruction and stalls on busy/done.
- Owns DMem port A (read-only) and port B (read/write) while busy.

Parameters:
- ADDR_W, 10, DMem address width; all addresses wrap modulo 2^ADDR_W.
- DATA_W, 16, element width.
- LEN_W, 16, vector length counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  request; sampled only in IDLE.
- op  in  4  0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR, 5 COPY (a); 6-15 illegal.
- src_a  in  16  base of vector A; low ADDR_W bits used.
- src_b  in  16  base of vector B.
- dst  in  16  base of result vector.
- len  in  LEN_W  element count.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle completion pulse.
- err  out  1  set with done on an illegal op; held until the next accepted start.
- elem_idx  out  LEN_W  index of the element in flight.
- mem_addra  out  ADDR_W  port A read address.
- mem_douta  in  DATA_W  port A read data (registered BRAM, 1-cycle latency).
- mem_web  out  1  port B write enable.
- mem_addrb  out  ADDR_W  port B address.
- mem_dinb  out  DATA_W  port B write data.
- mem_doutb  in  DATA_W  port B read data (1-cycle latency).

Behaviour:
- Reset asserted: state IDLE. busy, done, err, mem_web = 0. Addresses, mem_dinb, elem_idx and internal operand registers = 0. Takes effect immediately (asynchronous), including mid-write.
- States: IDLE, RD, WT, WR, FIN.
- IDLE: on start=1 at an edge, latch op/src_a/src_b/dst/len and clear err and elem_idx.
  - illegal op -> FIN with err=1; no memory access.
  - len=0 -> FIN.
  - otherwise -> RD.
- RD: mem_addra = src_a+i, mem_addrb = src_b+i, mem_web=0 -> WT.
- WT: BRAM data valid; at end of cycle latch opa=mem_douta, opb=mem_doutb -> WR.
- WR: mem_web=1, mem_addrb = dst+i, mem_dinb = f(op, opa, opb). f is computed mod 2^DATA_W; SUB wraps, no flags.
  - i == len-1 -> FIN.
  - otherwise i <= i+1 -> RD.
- FIN: done=1 for exactly one cycle -> IDLE. busy is still 1 in FIN and 0 in the following IDLE cycle.
- Timing: 3 cycles per element. For len=N, done is high in cycle 3N+1 after the start-sampling edge; 1 for len=0 or an illegal op.
- mem_web is 1 only in WR.
- Addresses are (base + i) truncated to ADDR_W, wrapping past 2^ADDR_W-1 to 0.
- start while busy: ignored, not queued. Inputs may change freely after acceptance.
- Ordering is ascending and each element is read before it is written, so in-place operation (dst == src_a or dst == src_b) is correct.
- Overlap with dst offset from a source (e.g. dst = src_a+1) reads already-written values. This is defined behaviour, not an error.
- len = 2^LEN_W-1 is the maximum; no length overflow is possible.

Optional Feature:
- Macro: VEC_STRIDE_EN.
- When defined, adds inputs stride_a, stride_b, stride_d (each 16 bits, latched at start).
  - Element i addresses become base + i*stride, truncated to ADDR_W.
  - Implemented with running address accumulators (add stride per element), not a multiplier.
  - Stride 0 is legal: broadcast a scalar source, or reduce into a single destination word with last-write-wins.
- When undefined: ports are absent and stride is fixed at 1.

Test Plan:
- ADD, src_a=0x010 with A={1,2,3,4}, src_b=0x020 with B={10,20,30,40}, dst=0x030, len=4 -> DMem[0x030..0x033]={11,22,33,44}; done in cycle 13; busy high cycles 1-13; exactly 4 mem_web pulses.
- SUB, A={0}, B={1}, len=1 -> dst word = 0xFFFF; err=0.
- len=0 or op=7 -> done in cycle 1, no mem_web. err=0 for len=0; err=1 for op=7, cleared by the next start.
- COPY, src_a=0x3FE, dst=0x100, len=4 -> reads 0x3FE, 0x3FF, 0x000, 0x001 (wrap); writes to 0x100-0x103.
- Start held high throughout a len=2 XOR, plus an extra start pulse while busy -> exactly one operation. In-place case (dst=src_a) gives A^B.
- Reset driven low during WR of element 2 of 5 -> mem_web and busy drop without waiting for an edge; elements 0-1 written, 2-4 untouched; a new start after release runs normally.
  - With VEC_STRIDE_EN defined, also run stride_a=2, stride_d=0 -> dst holds the last element result.
